cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 116 +++++++++++
 tb/tb_cordic_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Round-robin issue scheduler for a shared fixed-latency CORDIC pipeline.
// A {valid,id} tag rides alongside the datapath so each result returns to its owner.
module cordic_sched #(
    parameter int NREQ   = 4,
    parameter int LAT    = 20,
    parameter int MAXOUT = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int OW    = $clog2(MAXOUT) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*16-1:0]  req_x,
    input  logic [NREQ*16-1:0]  req_y,
    output logic [NREQ-1:0]     req_ready,
    output logic [15:0]         dp_x,
    output logic [15:0]         dp_y,
    output logic                dp_ena,
    input  logic [15:0]         dp_ang,
    input  logic [19:0]         dp_rad,
    output logic                res_valid,
    output logic [IDW-1:0]      res_id,
    output logic [15:0]         res_ang,
    output logic [19:0]         res_rad,
    input  logic                res_ready,
    output logic                busy
);

    logic [LAT-1:0]  tag_v;
    logic [IDW-1:0]  tag_id [LAT];
    logic [IDW-1:0]  rr;
    logic [OW-1:0]   outstanding [NREQ];

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] issue;
    logic [NREQ-1:0] retire;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic            issue_any;
    int              scan_idx;

    // Results come straight off the last tag slot so they stay aligned with dp_ang/dp_rad.
    assign res_valid = tag_v[LAT-1];
    assign res_id    = tag_id[LAT-1];
    assign res_ang   = dp_ang;
    assign res_rad   = dp_rad;
    assign dp_ena    = !(res_valid && !res_ready);
    assign busy      = |tag_v;
    assign issue_any = grant_found && dp_ena && !rst;
    assign req_ready = issue;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < OW'(MAXOUT));
            issue[i]    = issue_any && (grant_id == IDW'(i));
            retire[i]   = res_valid && res_ready && (res_id == IDW'(i));
        end
    end

    // NOTE: every variable gets a default before the search loop so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!grant_found && eligible[IDW'(scan_idx)]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        dp_x = '0;
        dp_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue[i]) begin
                dp_x = req_x[16*i +: 16];
                dp_y = req_y[16*i +: 16];
            end
        end
    end

    // NOTE: the tag array is reset because stale valid bits would emit phantom results;
    // the datapath itself carries no reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            rr    <= '0;
            for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
            for (int i = 0; i < NREQ; i++) outstanding[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every slot shift from its old neighbour.
            if (dp_ena) begin
                tag_v[0]  <= issue_any;
                tag_id[0] <= issue_any ? grant_id : '0;
                for (int i = 1; i < LAT; i++) begin
                    tag_v[i]  <= tag_v[i-1];
                    tag_id[i] <= tag_id[i-1];
                end
            end
            if (issue_any)
                rr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                case ({issue[i], retire[i]})
                    2'b10:   if (outstanding[i] != OW'(MAXOUT)) outstanding[i] <= outstanding[i] + 1'b1;
                    2'b01:   if (outstanding[i] != '0) outstanding[i] <= outstanding[i] - 1'b1;
                    default: outstanding[i] <= outstanding[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a stand-in delay-line datapath plus a queue-based scheduling model.
// Directed phases cover the key scenarios, then a long randomized phase.
module tb_cordic_sched;

    localparam int NREQ   = 4;
    localparam int LAT    = 20;
    localparam int MAXOUT = 8;
    localparam int IDW    = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*16-1:0]  req_x;
    logic [NREQ*16-1:0]  req_y;
    logic [NREQ-1:0]     req_ready;
    logic [15:0]         dp_x;
    logic [15:0]         dp_y;
    logic                dp_ena;
    logic [15:0]         dp_ang;
    logic [19:0]         dp_rad;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [15:0]         res_ang;
    logic [19:0]         res_rad;
    logic                res_ready;
    logic                busy;

    cordic_sched #(.NREQ(NREQ), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .dp_x(dp_x), .dp_y(dp_y), .dp_ena(dp_ena), .dp_ang(dp_ang), .dp_rad(dp_rad),
        .res_valid(res_valid), .res_id(res_id), .res_ang(res_ang), .res_rad(res_rad),
        .res_ready(res_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in datapath: ang = y, rad = zero-extended x, delayed LAT enabled clocks.
    logic [15:0] pipe_ang [LAT];
    logic [19:0] pipe_rad [LAT];
    always @(posedge clk) begin
        if (dp_ena) begin
            pipe_ang[0] <= dp_y;
            pipe_rad[0] <= {4'h0, dp_x};
            for (int i = 1; i < LAT; i++) begin
                pipe_ang[i] <= pipe_ang[i-1];
                pipe_rad[i] <= pipe_rad[i-1];
            end
        end
    end
    assign dp_ang = pipe_ang[LAT-1];
    assign dp_rad = pipe_rad[LAT-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: in-flight ops in issue order, each stamped with the enabled-clock count.
    typedef struct {
        int          id;
        logic [15:0] x;
        logic [15:0] y;
        int          ena;
    } op_t;

    op_t q[$];
    int  m_rr;
    int  m_out [NREQ];
    int  ena_cnt = 0;
    int  n_ret   = 0;

    logic            obs_valid;
    logic            obs_ena;
    logic            obs_busy;
    logic [NREQ-1:0] obs_ready;
    logic [IDW-1:0]  obs_id;
    logic [15:0]     obs_ang;

    task automatic model_step();
        logic            exp_valid;
        logic            exp_ena;
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_ready;
        logic [15:0]     ex;
        logic [15:0]     ey;
        op_t             op;
        obs_valid = res_valid;
        obs_ena   = dp_ena;
        obs_busy  = busy;
        obs_ready = req_ready;
        obs_id    = res_id;
        obs_ang   = res_ang;
        if (rst) begin
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_dp_ena",    32'(dp_ena),    32'd1);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            m_rr = 0;
            for (int i = 0; i < NREQ; i++) m_out[i] = 0;
            q.delete();
            return;
        end
        exp_valid = 1'b0;
        if (q.size() > 0) exp_valid = ((ena_cnt - q[0].ena) == LAT);
        exp_ena = !(exp_valid && !res_ready);
        g = -1;
        if (exp_ena) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[idx] && m_out[idx] < MAXOUT) g = idx;
            end
        end
        exp_ready = '0;
        ex = '0;
        ey = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ex = req_x[16*g +: 16];
            ey = req_y[16*g +: 16];
        end
        check("res_valid", 32'(res_valid), 32'(exp_valid));
        check("dp_ena",    32'(dp_ena),    32'(exp_ena));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy",      32'(busy),      32'(q.size() > 0));
        check("dp_x",      32'(dp_x),      32'(ex));
        check("dp_y",      32'(dp_y),      32'(ey));
        if (exp_valid) begin
            check("res_id",  32'(res_id),  32'(q[0].id));
            check("res_ang", 32'(res_ang), 32'(q[0].y));
            check("res_rad", 32'(res_rad), {12'h0, q[0].x});
        end
        if (exp_ena) begin
            if (exp_valid && res_ready) begin
                m_out[q[0].id]--;
                void'(q.pop_front());
                n_ret++;
            end
            if (g >= 0) begin
                op.id  = g;
                op.x   = ex;
                op.y   = ey;
                op.ena = ena_cnt;
                q.push_back(op);
                m_out[g]++;
                m_rr = (g + 1) % NREQ;
            end
            ena_cnt++;
        end
    endtask

    // One clock: check at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            req_x[16*i +: 16] = 16'($urandom);
            req_y[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        res_ready = 1'b1;
        repeat (n) step();
    endtask

    int cnt_a;
    int cnt_b;
    int first_c;
    int ret0;
    logic [IDW-1:0] id_at;
    logic [15:0]    ang_at;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b1;
        repeat (3) step();

        // Single op on requester 0, issued on the first edge after reset release.
        rst = 1'b0;
        req_valid = 4'b0001;
        req_x[15:0] = 16'h4000;
        req_y[15:0] = 16'h0000;
        step();
        req_valid = '0;
        cnt_a = 0;
        first_c = -1;
        id_at = '1;
        ang_at = '1;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (obs_valid) begin
                cnt_a++;
                if (first_c < 0) begin
                    first_c = c;
                    id_at   = obs_id;
                    ang_at  = obs_ang;
                end
            end
        end
        check("single_latency", 32'(first_c), 32'd20);
        check("single_pulses",  32'(cnt_a),   32'd1);
        check("single_id",      32'(id_at),   32'd0);
        check("single_ang",     32'(ang_at),  32'd0);

        // Round-robin with all requesters active from a fresh pointer.
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            rand_data();
            step();
            if (c < 8) check("rr_order", 32'(obs_ready), 32'(1 << (c % NREQ)));
        end
        drain(LAT + 5);

        // Back-pressure: stream to requester 2, block results for 5 cycles.
        req_valid = 4'b0100;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 45; c++) begin
            rand_data();
            res_ready = !(c >= 21 && c <= 25);
            step();
            if (!obs_ena) cnt_a++;
            if (!obs_ena && obs_valid && obs_ready == '0) cnt_b++;
        end
        check("bp_stall_cycles", 32'(cnt_a), 32'd5);
        check("bp_stall_blocked", 32'(cnt_b), 32'd5);
        drain(LAT + 10);

        // Credit limit on requester 0.
        req_valid = 4'b0001;
        res_ready = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 30; c++) begin
            rand_data();
            step();
            if (obs_ready[0]) cnt_a++;
        end
        check("credit_accepts", 32'(cnt_a), 32'd8);
        for (int c = 0; c < 7; c++) begin
            res_ready = (c < 2);
            step();
            if (obs_ready[0]) cnt_a++;
        end
        check("credit_after_retire", 32'(cnt_a), 32'd9);
        drain(LAT + 25);

        // Reset in the middle of a burst discards everything in flight.
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
        end
        do_reset();
        req_valid = '0;
        cnt_a = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (obs_valid || obs_busy) cnt_a++;
        end
        check("midrst_quiet", 32'(cnt_a), 32'd0);
        ret0 = n_ret;
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
        end
        drain(LAT + 10);
        check("midrst_new_results", 32'(n_ret - ret0), 32'd5);

        // Randomized traffic with random back-pressure and rare resets.
        for (int c = 0; c < 1500; c++) begin
            req_valid = NREQ'($urandom);
            rand_data();
            res_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end
        drain(LAT + 20);
        check("final_idle", 32'(obs_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
